// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD image controller and its host-side command issuer.
package lcd_ctrl_pkg;
  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE       = 4'd0,
    CMD_SHIFT_UP    = 4'd1,
    CMD_SHIFT_DOWN  = 4'd2,
    CMD_SHIFT_LEFT  = 4'd3,
    CMD_SHIFT_RIGHT = 4'd4,
    CMD_MAX_OP      = 4'd5,
    CMD_MIN_OP      = 4'd6,
    CMD_AVERAGE     = 4'd7,
    CMD_ROT_CCW     = 4'd8,
    CMD_ROT_CW      = 4'd9,
    CMD_MIRROR_X    = 4'd10,
    CMD_MIRROR_Y    = 4'd11
  } lcd_cmd_e;

  localparam logic [CMD_W-1:0] CMD_MAX = 4'd11;

  typedef enum logic [2:0] {
    ST_BOOT, ST_READY, ST_ACK, ST_WAIT, ST_WDONE, ST_DONE, ST_ERR
  } host_state_e;

  function automatic logic cmd_legal(input logic [CMD_W-1:0] c);
    return c <= CMD_MAX;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with an extra pointer wrap bit for full/empty detection.
module cmd_fifo
  import lcd_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end

  // storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/lcd_cmd_host.sv
// Host-side command issuer: buffers upstream commands and issues them one at a time
// on cmd/cmd_valid, pacing on the controller's busy/done handshake.
module lcd_cmd_host
  import lcd_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] in_cmd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  output logic             host_done,
  output logic             err_timeout,
  output logic             err_illegal,
  output logic [7:0]       issued_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);

  host_state_e      state, state_nxt;
  logic [CMD_W-1:0] head;
  logic [TW-1:0]    tcnt;
  logic             full, empty, accept, push, pop;
  logic             sealed, last_write, waiting;

  assign in_ready = !full && !sealed;
  assign accept   = in_valid && in_ready;
  assign push     = accept && cmd_legal(in_cmd);
  assign pop      = (state == ST_READY) && !empty && !lcd_busy;
  assign waiting  = state inside {ST_BOOT, ST_ACK, ST_WAIT, ST_WDONE};

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (in_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:  if (!lcd_busy) state_nxt = ST_READY;
      ST_READY: if (pop)       state_nxt = ST_ACK;
      ST_ACK:   if (lcd_busy)  state_nxt = ST_WAIT;
      ST_WAIT:  if (!lcd_busy) state_nxt = last_write ? ST_WDONE : ST_READY;
      ST_WDONE: if (lcd_done)  state_nxt = ST_DONE;
      default:  state_nxt = state;
    endcase
    // ERR once a wait state has been held for TIMEOUT cycles without its exit condition
    if (waiting && (state_nxt == state) && (tcnt == TW'(TIMEOUT - 1)))
      state_nxt = ST_ERR;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= ST_BOOT;
      tcnt        <= '0;
      cmd         <= '0;
      cmd_valid   <= 1'b0;
      last_write  <= 1'b0;
      sealed      <= 1'b0;
      host_done   <= 1'b0;
      err_timeout <= 1'b0;
      err_illegal <= 1'b0;
      issued_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      tcnt      <= ((state_nxt != state) || !waiting) ? '0 : tcnt + TW'(1);
      cmd_valid <= pop;
      if (pop) begin
        cmd        <= head;
        last_write <= (head == CMD_WRITE);
        issued_cnt <= issued_cnt + 8'd1;
      end
      if (accept && (in_cmd == CMD_WRITE)) sealed      <= 1'b1;
      if (accept && !cmd_legal(in_cmd))    err_illegal <= 1'b1;
      if ((state == ST_WDONE) && (state_nxt == ST_DONE)) host_done <= 1'b1;
      if ((state != ST_ERR) && (state_nxt == ST_ERR))    err_timeout <= 1'b1;
    end
endmodule
